// File: rtl/cache_set_requester.sv
// Cache-set requester: turns core load/store requests into single set commands,
// retries write misses as forced fills and returns one response per request.
// Optional build macro CACHE_REQ_STATS_EN adds saturating hit/miss/error counters.
module cache_set_requester #(
    parameter int unsigned TIMEOUT   = 16,
    parameter int unsigned MAX_RETRY = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    // Core-side request
    input  logic         req_valid_i,
    output logic         req_ready_o,
    input  logic         req_write_i,
    input  logic [35:0]  req_addr_i,
    input  logic [1:0]   req_size_i,
    input  logic [63:0]  req_wdata_i,
    // Core-side response
    output logic         resp_valid_o,
    input  logic         resp_ready_i,
    output logic [63:0]  resp_rdata_o,
    output logic         resp_miss_o,
    output logic         resp_err_o,
    // Set command
    output logic         set_enable_o,
    output logic         set_write_enable_o,
    output logic         set_force_write_o,
    output logic [23:0]  set_tag_o,
    output logic [5:0]   set_idx_o,
    output logic [5:0]   set_block_offset_o,
    output logic [1:0]   set_data_size_o,
    output logic [63:0]  set_write_data_o,
    output logic [31:0]  set_n_ops_o,
    // Set response
    input  logic [127:0] set_out_data_i,
    input  logic         set_data_ready_i,
    input  logic         set_read_miss_i,
    input  logic         set_write_miss_i,
    input  logic         set_op_done_i
`ifdef CACHE_REQ_STATS_EN
    ,
    output logic [31:0]  stat_hits_o,
    output logic [31:0]  stat_misses_o,
    output logic [31:0]  stat_errs_o
`endif
);

    typedef enum logic [2:0] {
        StIdle,
        StCheck,
        StIssue,
        StWait,
        StFill,
        StResp
    } state_e;

    state_e      state_q, state_d;
    logic [35:0] addr_q, addr_d;
    logic [1:0]  size_q, size_d;
    logic        write_q, write_d;
    logic [63:0] wdata_q, wdata_d;
    logic [31:0] n_ops_q, n_ops_d;
    logic [31:0] retry_q, retry_d;
    logic [31:0] tmo_q, tmo_d;
    logic [63:0] rdata_q, rdata_d;
    logic        miss_q, miss_d;
    logic        err_q, err_d;

    logic [5:0]  offset;
    logic [6:0]  size_bytes;
    logic        misaligned;
    logic        crossing;
    logic [63:0] size_mask;
    logic        unused_upper;

    assign offset     = addr_q[5:0];
    assign size_bytes = 7'd1 << size_q;
    assign misaligned = (({1'b0, offset} & (size_bytes - 7'd1)) != 7'd0);
    assign crossing   = (({1'b0, offset} + size_bytes) > 7'd64);

    // Only the low half of the set read port carries data for this requester.
    assign unused_upper = ^set_out_data_i[127:64];

    // Right-aligned mask selecting the bytes covered by the request size.
    always_comb begin
        size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
        case (size_q)
            2'd0:    size_mask = 64'h0000_0000_0000_00FF;
            2'd1:    size_mask = 64'h0000_0000_0000_FFFF;
            2'd2:    size_mask = 64'h0000_0000_FFFF_FFFF;
            default: size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    end

    // Next-state logic for the request FSM and its datapath registers.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        size_d  = size_q;
        write_d = write_q;
        wdata_d = wdata_q;
        n_ops_d = n_ops_q;
        retry_d = retry_q;
        tmo_d   = tmo_q;
        rdata_d = rdata_q;
        miss_d  = miss_q;
        err_d   = err_q;

        case (state_q)
            StIdle: begin
                if (req_valid_i) begin
                    addr_d  = req_addr_i;
                    size_d  = req_size_i;
                    write_d = req_write_i;
                    wdata_d = req_wdata_i;
                    state_d = StCheck;
                end
            end
            StCheck: begin
                if (misaligned || crossing) begin
                    err_d   = 1'b1;
                    state_d = StResp;
                end else begin
                    state_d = StIssue;
                end
            end
            StIssue: begin
                n_ops_d = n_ops_q + 32'd1;
                tmo_d   = 32'd0;
                state_d = StWait;
            end
            StWait: begin
                tmo_d = tmo_q + 32'd1;
                if (set_read_miss_i) begin
                    miss_d  = 1'b1;
                    rdata_d = 64'd0;
                    state_d = StResp;
                end else if (set_write_miss_i) begin
                    if (retry_q < MAX_RETRY) begin
                        state_d = StFill;
                    end else begin
                        miss_d  = 1'b1;
                        state_d = StResp;
                    end
                end else if (set_data_ready_i && !write_q) begin
                    rdata_d = set_out_data_i[63:0] & size_mask;
                    state_d = StResp;
                end else if (set_op_done_i && write_q) begin
                    state_d = StResp;
                end else if ((tmo_q + 32'd1) >= TIMEOUT) begin
                    err_d   = 1'b1;
                    state_d = StResp;
                end
            end
            StFill: begin
                retry_d = retry_q + 32'd1;
                n_ops_d = n_ops_q + 32'd1;
                tmo_d   = 32'd0;
                state_d = StWait;
            end
            StResp: begin
                if (resp_ready_i) begin
                    rdata_d = 64'd0;
                    miss_d  = 1'b0;
                    err_d   = 1'b0;
                    retry_d = 32'd0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers; reset abandons any in-flight command.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            addr_q  <= '0;
            size_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            n_ops_q <= '0;
            retry_q <= '0;
            tmo_q   <= '0;
            rdata_q <= '0;
            miss_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
            n_ops_q <= n_ops_d;
            retry_q <= retry_d;
            tmo_q   <= tmo_d;
            rdata_q <= rdata_d;
            miss_q  <= miss_d;
            err_q   <= err_d;
        end
    end

    // Outputs decoded from state; command fields come straight from the request register.
    always_comb begin
        req_ready_o        = (state_q == StIdle);
        resp_valid_o       = (state_q == StResp);
        resp_rdata_o       = rdata_q;
        resp_miss_o        = miss_q;
        resp_err_o         = err_q;
        set_enable_o       = (state_q == StIssue) || (state_q == StFill);
        set_force_write_o  = (state_q == StFill);
        set_write_enable_o = (state_q == StFill) ||
                             (write_q && ((state_q == StIssue) || (state_q == StWait)));
        set_tag_o          = addr_q[35:12];
        set_idx_o          = addr_q[11:6];
        set_block_offset_o = addr_q[5:0];
        set_data_size_o    = size_q;
        set_write_data_o   = wdata_q;
        set_n_ops_o        = n_ops_q;
    end

`ifdef CACHE_REQ_STATS_EN
    logic [31:0] hits_q, misses_q, errs_q;
    logic        resp_fire;

    assign resp_fire = (state_q == StResp) && resp_ready_i;

    // Saturating per-kind response counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hits_q   <= '0;
            misses_q <= '0;
            errs_q   <= '0;
        end else if (resp_fire) begin
            if (err_q) begin
                if (errs_q != 32'hFFFF_FFFF) errs_q <= errs_q + 32'd1;
            end else if (miss_q) begin
                if (misses_q != 32'hFFFF_FFFF) misses_q <= misses_q + 32'd1;
            end else begin
                if (hits_q != 32'hFFFF_FFFF) hits_q <= hits_q + 32'd1;
            end
        end
    end

    assign stat_hits_o   = hits_q;
    assign stat_misses_o = misses_q;
    assign stat_errs_o   = errs_q;
`endif

endmodule

// File: tb/tb_cache_set_requester.sv
// Directed bench for cache_set_requester: hit, misaligned, fill retry, misses,
// size masking, timeout with backpressure and asynchronous reset mid-access.
module tb_cache_set_requester;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req_valid, req_ready, req_write;
    logic [35:0]  req_addr;
    logic [1:0]   req_size;
    logic [63:0]  req_wdata;
    logic         resp_valid, resp_ready, resp_miss, resp_err;
    logic [63:0]  resp_rdata;
    logic         set_enable, set_write_enable, set_force_write;
    logic [23:0]  set_tag;
    logic [5:0]   set_idx, set_block_offset;
    logic [1:0]   set_data_size;
    logic [63:0]  set_write_data;
    logic [31:0]  set_n_ops;
    logic [127:0] set_out_data;
    logic         set_data_ready, set_read_miss, set_write_miss, set_op_done;
`ifdef CACHE_REQ_STATS_EN
    logic [31:0]  stat_hits, stat_misses, stat_errs;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    cache_set_requester #(.TIMEOUT(16), .MAX_RETRY(1)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .req_valid_i        (req_valid),
        .req_ready_o        (req_ready),
        .req_write_i        (req_write),
        .req_addr_i         (req_addr),
        .req_size_i         (req_size),
        .req_wdata_i        (req_wdata),
        .resp_valid_o       (resp_valid),
        .resp_ready_i       (resp_ready),
        .resp_rdata_o       (resp_rdata),
        .resp_miss_o        (resp_miss),
        .resp_err_o         (resp_err),
        .set_enable_o       (set_enable),
        .set_write_enable_o (set_write_enable),
        .set_force_write_o  (set_force_write),
        .set_tag_o          (set_tag),
        .set_idx_o          (set_idx),
        .set_block_offset_o (set_block_offset),
        .set_data_size_o    (set_data_size),
        .set_write_data_o   (set_write_data),
        .set_n_ops_o        (set_n_ops),
        .set_out_data_i     (set_out_data),
        .set_data_ready_i   (set_data_ready),
        .set_read_miss_i    (set_read_miss),
        .set_write_miss_i   (set_write_miss),
        .set_op_done_i      (set_op_done)
`ifdef CACHE_REQ_STATS_EN
        ,
        .stat_hits_o        (stat_hits),
        .stat_misses_o      (stat_misses),
        .stat_errs_o        (stat_errs)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Presents one request for a single accepting edge; leaves the DUT in CHECK.
    task automatic send(input logic w, input logic [23:0] tag, input logic [5:0] idx,
                        input logic [5:0] off, input logic [1:0] sz, input logic [63:0] wd);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = {tag, idx, off};
        req_size  = sz;
        req_wdata = wd;
        tick();
        req_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_size = '0; req_wdata = '0;
        resp_ready = 1'b1;
        set_out_data = '0; set_data_ready = 1'b0; set_read_miss = 1'b0;
        set_write_miss = 1'b0; set_op_done = 1'b0;
        tick();
        tick();
        chk("rst_req_ready", req_ready, 1);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_set_enable", set_enable, 0);
        chk("rst_n_ops", set_n_ops, 0);
        chk("rst_rdata", resp_rdata, 0);
        rst_n = 1'b1;
        tick();

        // Load hit, size 2 at tag 1 / set 2 / offset 8
        send(1'b0, 24'h000001, 6'd2, 6'd8, 2'd2, 64'd0);
        chk("hit_req_ready_drop", req_ready, 0);
        chk("hit_check_no_enable", set_enable, 0);
        tick();
        chk("hit_issue_enable", set_enable, 1);
        chk("hit_tag", set_tag, 24'h000001);
        chk("hit_idx", set_idx, 6'd2);
        chk("hit_offset", set_block_offset, 6'd8);
        chk("hit_size", set_data_size, 2'd2);
        chk("hit_we", set_write_enable, 0);
        chk("hit_force", set_force_write, 0);
        chk("hit_n_ops_issue", set_n_ops, 0);
        tick();
        chk("hit_wait_no_enable", set_enable, 0);
        chk("hit_n_ops_wait", set_n_ops, 1);
        chk("hit_no_resp_yet", resp_valid, 0);
        set_data_ready = 1'b1;
        set_out_data   = {64'hA5A5_A5A5_A5A5_A5A5, 64'h1234_5678_DEAD_BEEF};
        tick();
        set_data_ready = 1'b0;
        chk("hit_resp_valid_4cyc", resp_valid, 1);
        chk("hit_rdata", resp_rdata, 64'h0000_0000_DEAD_BEEF);
        chk("hit_miss", resp_miss, 0);
        chk("hit_err", resp_err, 0);
        tick();
        chk("hit_done_resp_valid", resp_valid, 0);
        chk("hit_done_req_ready", req_ready, 1);

        // Misaligned: size 3 at offset 4
        send(1'b0, 24'h000055, 6'd0, 6'd4, 2'd3, 64'd0);
        chk("mis_check_no_enable", set_enable, 0);
        tick();
        chk("mis_resp_valid", resp_valid, 1);
        chk("mis_err", resp_err, 1);
        chk("mis_no_enable", set_enable, 0);
        chk("mis_n_ops_unchanged", set_n_ops, 1);
        tick();
        chk("mis_done", req_ready, 1);

        // Write miss then forced fill, starting from a fresh sequence count
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        tick();
        send(1'b1, 24'hABCDEF, 6'd5, 6'd0, 2'd3, 64'h1122_3344_5566_7788);
        tick();
        chk("wm_issue_enable", set_enable, 1);
        chk("wm_issue_we", set_write_enable, 1);
        chk("wm_issue_force", set_force_write, 0);
        chk("wm_issue_n_ops", set_n_ops, 0);
        chk("wm_wdata", set_write_data, 64'h1122_3344_5566_7788);
        tick();
        set_write_miss = 1'b1;
        tick();
        set_write_miss = 1'b0;
        chk("wm_fill_enable", set_enable, 1);
        chk("wm_fill_force", set_force_write, 1);
        chk("wm_fill_we", set_write_enable, 1);
        chk("wm_fill_n_ops", set_n_ops, 1);
        tick();
        chk("wm_wait_no_enable", set_enable, 0);
        chk("wm_wait_n_ops", set_n_ops, 2);
        set_op_done = 1'b1;
        tick();
        set_op_done = 1'b0;
        chk("wm_resp_valid", resp_valid, 1);
        chk("wm_resp_miss", resp_miss, 0);
        chk("wm_resp_err", resp_err, 0);
        tick();

        // Write miss with the single retry exhausted
        send(1'b1, 24'h000010, 6'd1, 6'd8, 2'd3, 64'h0000_0000_0000_CAFE);
        tick();
        tick();
        set_write_miss = 1'b1;
        tick();
        chk("wx_fill_force", set_force_write, 1);
        tick();
        chk("wx_still_waiting", resp_valid, 0);
        tick();
        set_write_miss = 1'b0;
        chk("wx_resp_valid", resp_valid, 1);
        chk("wx_resp_miss", resp_miss, 1);
        chk("wx_n_ops", set_n_ops, 4);
        tick();

        // Read miss with a concurrent data_ready
        send(1'b0, 24'h0000FF, 6'd63, 6'd3, 2'd0, 64'd0);
        tick();
        tick();
        set_read_miss  = 1'b1;
        set_data_ready = 1'b1;
        set_out_data   = {128{1'b1}};
        tick();
        set_read_miss  = 1'b0;
        set_data_ready = 1'b0;
        chk("rm_resp_valid", resp_valid, 1);
        chk("rm_resp_miss", resp_miss, 1);
        chk("rm_rdata_zero", resp_rdata, 0);
        chk("rm_err", resp_err, 0);
        tick();

        // Byte load: data masked to 8 bits
        send(1'b0, 24'h000002, 6'd7, 6'd3, 2'd0, 64'd0);
        tick();
        tick();
        set_data_ready = 1'b1;
        set_out_data   = {64'd0, 64'hFFEE_DDCC_BBAA_ABCD};
        tick();
        set_data_ready = 1'b0;
        chk("byte_rdata", resp_rdata, 64'h0000_0000_0000_00CD);
        chk("byte_miss", resp_miss, 0);
        tick();

        // Timeout with response backpressure
        resp_ready = 1'b0;
        send(1'b0, 24'h123456, 6'd10, 6'd16, 2'd3, 64'd0);
        tick();
        tick();
        repeat (15) tick();
        chk("tmo_not_before_16", resp_valid, 0);
        tick();
        chk("tmo_resp_valid", resp_valid, 1);
        chk("tmo_err", resp_err, 1);
        chk("tmo_miss", resp_miss, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_resp_valid", resp_valid, 1);
            chk("bp_err", resp_err, 1);
            chk("bp_req_ready", req_ready, 0);
        end
        resp_ready = 1'b1;
        tick();
        chk("bp_release", resp_valid, 0);
        chk("bp_err_cleared", resp_err, 0);
        chk("tmo_n_ops", set_n_ops, 7);

        // Asynchronous reset while waiting on the set
        send(1'b0, 24'h000003, 6'd4, 6'd0, 2'd3, 64'd0);
        tick();
        tick();
        chk("arst_in_wait", req_ready, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_req_ready", req_ready, 1);
        chk("arst_n_ops", set_n_ops, 0);
        chk("arst_enable", set_enable, 0);
        rst_n = 1'b1;
        tick();
        tick();
        chk("arst_no_resp", resp_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cache_set_requester.md
Name: cache_set_requester

Overview:
- Initiator side of the cache-set access interface; converts CPU-style load/store requests into set commands and collects the responses.
- Splits a 36-bit physical address into tag[23:0], set index[5:0] and block offset[5:0].
- Drives one set access per request and retries write misses as a forced fill.
- Sits between the core-side load/store port and the cache set array.

Parameters:
- TIMEOUT, 16, max cycles in WAIT before aborting the access with an error.
- MAX_RETRY, 1, number of forced-fill reissues allowed after a write miss.

Ports:
- clk  in  1  clock, all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  core request valid.
- req_ready  out  1  requester can accept a request (high only in IDLE).
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  36  physical address: [35:12] tag, [11:6] set, [5:0] offset.
- req_size  in  2  0: 8, 1: 16, 2: 32, 3: 64 bits.
- req_wdata  in  64  store data, right-aligned.
- resp_valid  out  1  response valid.
- resp_ready  in  1  core accepts the response.
- resp_rdata  out  64  load data, right-aligned, zero-extended.
- resp_miss  out  1  the access missed (read miss, or write miss after retries exhausted).
- resp_err  out  1  misaligned access or timeout.
- set_enable  out  1  one-cycle command strobe to the set.
- set_write_enable  out  1  command is a write.
- set_force_write  out  1  command is a forced fill or evict write.
- set_tag  out  24  tag field.
- set_idx  out  6  set index.
- set_block_offset  out  6  byte offset.
- set_data_size  out  2  size code.
- set_write_data  out  64  write data.
- set_n_ops  out  32  operation sequence number.
- set_out_data  in  128  read data from the set; bits [63:0] are used.
- set_data_ready  in  1  read data valid.
- set_read_miss  in  1  read miss.
- set_write_miss  in  1  write miss.
- set_op_done  in  1  set finished the command.

Behaviour:
- Reset state: FSM in IDLE; all outputs 0 except req_ready = 1; set_n_ops = 0; retry count = 0; timeout counter = 0.
- States: IDLE, CHECK, ISSUE, WAIT, FILL, RESP.
- IDLE:
  - When req_valid && req_ready, latch addr/size/write/wdata into a request register and go to CHECK.
  - req_ready drops the next cycle.
- CHECK (1 cycle):
  - Misaligned if (offset mod 2^size) != 0; boundary crossing if offset + 2^size > 64.
  - Either condition: resp_err = 1, go to RESP with no set access.
  - Otherwise go to ISSUE.
- ISSUE (1 cycle):
  - set_enable = 1; command fields driven from the request register.
  - set_force_write = 0; set_n_ops is the current count.
  - Go to WAIT; set_n_ops increments at exit, wrapping 0xFFFFFFFF -> 0.
- WAIT:
  - Command fields stay stable; set_enable = 0; timeout counter increments each cycle.
  - Priority: miss > data_ready > op_done.
  - set_read_miss: resp_miss = 1, resp_rdata = 0, go to RESP.
  - set_write_miss with retries < MAX_RETRY: go to FILL.
  - set_write_miss with retries exhausted: resp_miss = 1, go to RESP.
  - set_data_ready on a load: capture set_out_data[63:0] masked to the request size, go to RESP.
  - set_op_done alone on a store: go to RESP (hit).
  - Counter reaches TIMEOUT with no response: resp_err = 1, go to RESP.
  - Counter clears on WAIT entry.
- FILL (1 cycle):
  - set_enable = 1, set_write_enable = 1, set_force_write = 1.
  - Retry count increments; set_n_ops increments; go back to WAIT.
- RESP:
  - resp_valid = 1; resp fields are stable until resp_ready.
  - On resp_valid && resp_ready: clear resp fields and retry count, go to IDLE.
  - resp_ready held high entering RESP gives a 1-cycle response.
- Latency: an aligned load hit with set_data_ready returned 1 cycle after set_enable takes 4 cycles from accept to resp_valid.
- Exactly one set_enable pulse per ISSUE/FILL; set_enable is never high in two consecutive cycles.
- Response inputs arriving outside WAIT are ignored.
- rst_n asserted mid-operation: immediate return to reset state; any in-flight set command is abandoned with no response.

Optional Feature:
- Macro CACHE_REQ_STATS_EN.
- Defined: adds outputs stat_hits[31:0], stat_misses[31:0] and stat_errs[31:0], each incremented once per completed response (resp_valid && resp_ready) of its kind, saturating at 0xFFFFFFFF, reset to 0.
- Undefined: these ports and counters do not exist; all other behaviour is unchanged.

Test Plan:
- Load hit: req addr 0x000001_02_08, size 2, set returns data_ready with out_data 0xDEADBEEF 1 cycle later -> set_tag 0x000001, set_idx 2, set_block_offset 8; resp_rdata 0xDEADBEEF, miss 0, err 0, resp_valid 4 cycles after accept.
- Misaligned: size 3 at offset 4 -> no set_enable pulse; resp_err 1 two cycles after accept.
- Write miss then fill: store, set returns write_miss -> FILL pulse with force_write 1; set_n_ops goes 0 then 1; set returns op_done -> resp_miss 0.
- Read miss: set returns read_miss -> resp_miss 1, resp_rdata 0; a concurrent data_ready is ignored.
- Timeout plus backpressure: no set response for 16 cycles -> resp_err 1; resp_ready held low for 5 cycles -> resp fields stable; rst_n pulsed while in WAIT -> req_ready 1 and set_n_ops 0 immediately.
